// File: rtl/keypad_scanner_if.sv
// Pin-side and consumer-side signals of the keypad scanner.
// master = scanner (drives rows and digit events), slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic       key_valid;
  logic [3:0] key_number;
  logic       key_ready;
  logic       overrun;

  modport master (
    input  col_in,
    input  key_ready,
    output row_out,
    output key_valid,
    output key_number,
    output overrun
  );

  modport slave (
    output col_in,
    output key_ready,
    input  row_out,
    input  key_valid,
    input  key_number,
    input  overrun
  );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: row strobe, frame debounce, one digit event per press; event visible 4*SCAN_DIV*DEBOUNCE cycles after press.
// Single-entry holding register under valid/ready; an event arriving while it is full and not draining is dropped and flags sticky overrun.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {ROW_D = 2'd0, ROW_E = 2'd1, ROW_F = 2'd2, ROW_G = 2'd3} row_e;
  typedef enum logic [1:0] {CLS_NONE = 2'd0, CLS_KEY = 2'd1, CLS_BAD = 2'd2} cls_e;

  localparam logic [7:0] DWELL_MAX = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DB_MAX    = 4'(DEBOUNCE);

  row_e        row_q, row_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [11:0] acc_q, acc_d;
  cls_e        cand_cls_q, cand_cls_d;
  logic [3:0]  cand_dig_q, cand_dig_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pressed_q, pressed_d;
  logic        key_valid_q, key_valid_d;
  logic [3:0]  key_number_q, key_number_d;
  logic        overrun_q, overrun_d;

  logic        dwell_last;
  logic        frame_end;
  logic        same;
  logic        accept;
  logic        emit;
  logic [3:0]  ones;
  logic [3:0]  idx;
  logic [3:0]  frame_dig;
  cls_e        frame_cls;

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q        <= ROW_D;
      dwell_q      <= '0;
      acc_q        <= '0;
      cand_cls_q   <= CLS_NONE;
      cand_dig_q   <= '0;
      cnt_q        <= DB_MAX;
      pressed_q    <= 1'b0;
      key_valid_q  <= 1'b0;
      key_number_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      acc_q        <= acc_d;
      cand_cls_q   <= cand_cls_d;
      cand_dig_q   <= cand_dig_d;
      cnt_q        <= cnt_d;
      pressed_q    <= pressed_d;
      key_valid_q  <= key_valid_d;
      key_number_q <= key_number_d;
      overrun_q    <= overrun_d;
    end
  end

  // Row sequencer: advance one row at the end of each dwell.
  always_comb begin
    dwell_last = (dwell_q == DWELL_MAX);
    dwell_d    = dwell_last ? 8'd0 : dwell_q + 8'd1;
    row_d      = row_q;
    if (dwell_last) begin
      row_d = row_e'(row_q + 2'd1);
    end
  end

  // acc_d already holds the row-g columns on the frame edge, so it is the complete frame.
  always_comb begin
    acc_d = acc_q;
    if (dwell_last) begin
      unique case (row_q)
        ROW_D: acc_d[2:0]  = kp.col_in;
        ROW_E: acc_d[5:3]  = kp.col_in;
        ROW_F: acc_d[8:6]  = kp.col_in;
        ROW_G: acc_d[11:9] = kp.col_in;
      endcase
    end
    frame_end = dwell_last && (row_q == ROW_G);

    ones = '0;
    idx  = '0;
    for (int i = 0; i < 12; i++) begin
      if (acc_d[i]) begin
        ones = ones + 4'd1;
        idx  = 4'(i);
      end
    end

    frame_cls = CLS_BAD;
    frame_dig = '0;
    if (ones == 4'd0) begin
      frame_cls = CLS_NONE;
    end else if (ones == 4'd1 && idx != 4'd9 && idx != 4'd11) begin
      frame_cls = CLS_KEY;
      frame_dig = (idx == 4'd10) ? 4'd0 : idx + 4'd1;
    end
  end

  always_comb begin
    cand_cls_d = cand_cls_q;
    cand_dig_d = cand_dig_q;
    cnt_d      = cnt_q;
    pressed_d  = pressed_q;
    accept     = 1'b0;
    emit       = 1'b0;
    same       = (frame_cls == cand_cls_q) && (frame_dig == cand_dig_q);

    if (frame_end) begin
      if (same) begin
        if (cnt_q != DB_MAX) begin
          cnt_d  = cnt_q + 4'd1;
          accept = ((cnt_q + 4'd1) == DB_MAX);
        end
      end else begin
        cand_cls_d = frame_cls;
        cand_dig_d = frame_dig;
        cnt_d      = 4'd1;
        accept     = (DB_MAX == 4'd1);
      end
    end

    if (accept) begin
      unique case (frame_cls)
        CLS_KEY: begin
          emit      = !pressed_q;
          pressed_d = 1'b1;
        end
        CLS_BAD:  pressed_d = 1'b1;
        default:  pressed_d = 1'b0;
      endcase
    end
  end

  // A drain and a new load may share an edge; only a full, stalled register drops.
  always_comb begin
    key_valid_d  = key_valid_q;
    key_number_d = key_number_q;
    overrun_d    = overrun_q;
    if (emit) begin
      if (!key_valid_q || kp.key_ready) begin
        key_valid_d  = 1'b1;
        key_number_d = frame_dig;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (kp.key_ready) begin
      key_valid_d = 1'b0;
    end
  end

  always_comb begin
    unique case (row_q)
      ROW_D:   kp.row_out = 4'b0001;
      ROW_E:   kp.row_out = 4'b0010;
      ROW_F:   kp.row_out = 4'b0100;
      default: kp.row_out = 4'b1000;
    endcase
    kp.key_valid  = key_valid_q;
    kp.key_number = key_number_q;
    kp.overrun    = overrun_q;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Sequential scan controller for the 3-column × 4-row keypad matrix. It drives one row strobe at a time, samples the three column lines, and debounces whole scan frames. It emits one decoded digit 0–9 per debounced key press over a valid/ready handshake. It sits between the physical keypad pins and the downstream logic that consumes digit events, and it replaces the purely combinational decode path.

## Interface
- SCAN_DIV, 4: clock cycles each row strobe is held; legal range 2–255.
- DEBOUNCE, 3: consecutive identical frames required to accept a state; legal range 1–15.

- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- col_in  input  3  column sense, active-high. Bit0 = col a, bit1 = col b, bit2 = col c.
- row_out  output  4  one-hot row strobe, active-high. Bit0 = row d, bit1 = row e, bit2 = row f, bit3 = row g.
- key_valid  output  1  a digit event is pending.
- key_number  output  4  digit 0–9; stable while key_valid = 1.
- key_ready  input  1  consumer accepts the pending event when key_valid && key_ready.
- overrun  output  1  sticky; an event was dropped because the holding register was full.

## Operation
- Key map (row, col → digit):
  - d: a = 1, b = 2, c = 3
  - e: a = 4, b = 5, c = 6
  - f: a = 7, b = 8, c = 9
  - g: a = `*`, b = 0, c = `#`
- Row scan:
  - Dwell counter runs 0..SCAN_DIV-1 per row.
  - On the edge where the counter = SCAN_DIV-1, col_in is captured into the frame accumulator and row_out rotates d→e→f→g→d.
  - One frame = 4·SCAN_DIV cycles.
- Frame classification, evaluated at the row-g capture edge over all 12 sampled bits:
  - NONE: zero bits set.
  - KEY(n): exactly one bit set and it maps to a digit.
  - BAD: two or more bits set, or the single bit is `*` or `#`.
- Debounce registers: candidate (class + digit), cnt (0..DEBOUNCE), pressed flag.
  - If frame = candidate, cnt saturates at DEBOUNCE.
  - Otherwise candidate ← frame and cnt ← 1.
  - Accept: the frame edge on which cnt becomes DEBOUNCE (or candidate changes with DEBOUNCE = 1).
  - Accepted KEY(n) with pressed = 0: emit event n and set pressed.
  - Accepted BAD: set pressed; no event.
  - Accepted NONE: clear pressed.
  - A held key never repeats. A new event requires a debounced NONE between presses.
- Output holding register (one entry):
  - On emit, if key_valid = 0 or (key_valid && key_ready) on that edge: load key_number ← n and set key_valid.
  - On emit while key_valid && !key_ready: drop the event and set overrun.
  - Accept without emit: key_valid clears on the edge where key_ready = 1.
- overrun clears only on reset.

## Timing
- Reset values:
  - row_out = 4'b0001, key_valid = 0, key_number = 0, overrun = 0.
  - Dwell counter = 0; accumulator cleared.
  - candidate = NONE, cnt = DEBOUNCE, pressed = 0.
- Cycle 0 is the first cycle after reset deasserts; row d is driven in cycle 0.
- Frame k occupies cycles 16k..16k+15 (defaults). Its capture and evaluation happen on the edge ending the last cycle.
- key_valid rises in the first cycle of the frame following the accepting frame.
  - Key held from cycle 0, defaults: key_valid = 1 in cycle 48.
  - General case: cycle 4·SCAN_DIV·DEBOUNCE.
- col_in is sampled only at the capture edge. Column activity at any other time in the dwell is ignored, which gives SCAN_DIV-1 cycles of settle.
- Handshake:
  - key_valid drops the cycle after an edge with key_ready = 1, unless a new emit loads on that same edge; in that case key_valid stays 1 with the new key_number.
  - key_ready is ignored while key_valid = 0.
- Reset asserted mid-dwell or mid-handshake: all state returns to reset values on that edge. A pending event is lost; overrun is cleared.

## Test plan
- Reset; then drive col_in = 3'b010 whenever row_out = 4'b0010 (key 5), key_ready = 1 → key_valid high in cycle 48 only, key_number = 5. Hold key 20 more frames → no further events.
- Key 7 present in frames 0, 2, 3, 4, absent in frame 1 → single event key_number = 7, first visible in the cycle after frame 4's capture edge (cycle 80).
- Key 0 (row g, col b) → event with key_number = 0. Release, then `*` (row g, col a) and later `#` (row g, col c) held 5 frames each → no events, key_valid stays 0.
- Keys 1 and 2 together (row d, col_in = 3'b011) for 5 frames → no event. Release for 3 frames, press 3 → one event, key_number = 3.
- key_ready = 0: press/release 4, then press/release 9 → key_valid held with key_number = 4, 9 dropped, overrun = 1. Then key_ready = 1 for one cycle → key_valid = 0 next cycle; overrun stays 1.
- With key_valid = 1 pending and overrun = 1, assert reset for one cycle mid-dwell on row f → next cycle row_out = 4'b0001, key_valid = 0, key_number = 0, overrun = 0. Key 8 held after reset → event at cycle 48.
